// File: rtl/regfile_dump_ctrl_if.sv
// Read-port and output-stream bundle for the register-file dump sequencer.
// The master side is the sequencer; the slave side is the register file plus the consumer.
interface regfile_dump_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output rd_addr, out_valid, out_addr, out_data,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_addr, out_valid, out_addr, out_data,
        output rd_data, out_ready
    );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks a register address range through one register-file read port and streams
// {address, data} beats over a valid/ready handshake.
module regfile_dump_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   first_addr,
    input  logic [ADDR_W-1:0]   last_addr,
    regfile_dump_ctrl_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     beat_cnt
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last_q;
    logic              hs;

    always_comb begin
        hs = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_q        <= '0;
            bus.rd_addr   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beat_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // A beat completing in the abort cycle still counts as delivered.
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                busy          <= 1'b0;
                if (hs) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            last_q      <= last_addr;
                            bus.rd_addr <= first_addr;
                            beat_cnt    <= '0;
                            busy        <= 1'b1;
                            state       <= READ;
                        end
                    end
                    READ: begin
                        bus.out_addr  <= bus.rd_addr;
                        bus.out_data  <= bus.rd_data;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                    HOLD: begin
                        if (hs) begin
                            bus.out_valid <= 1'b0;
                            beat_cnt      <= beat_cnt + 1'b1;
                            if (bus.rd_addr == last_q) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                bus.rd_addr <= bus.rd_addr + 1'b1;
                                state       <= READ;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: table of dump ranges plus hand-written
// abort, reset-in-HOLD and start/abort-collision sequences.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        busy;
    logic        done;
    logic [5:0]  beat_cnt;
    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;

    regfile_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dump_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    // Combinational register-file read port
    always_comb begin
        bus.rd_data = regs[bus.rd_addr];
    end

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         beats;
        int         exp_done;
        logic [4:0] stall_addr;
        int         stall_len;
        bit         poke;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a dump and follows it to completion, checking every beat in order.
    task automatic run_dump(input vec_t v);
        int k = 0;
        int cyc;
        int dcnt = 0;
        int dcyc = -1;
        int stall = v.stall_len;
        logic hs;
        logic [4:0] ea;
        first_addr = v.first;
        last_addr  = v.last;
        start      = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        while (busy && cyc < 300) begin
            if (done) begin
                dcnt++;
                dcyc = cyc;
            end
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
                ea = v.first + k[4:0];
                chk("out_addr", {59'd0, bus.out_addr}, {59'd0, ea});
                chk("out_data", {32'd0, bus.out_data}, 64'h100 + ea);
                if (bus.out_addr == v.stall_addr && stall > 0) begin
                    bus.out_ready = 1'b0;
                    stall--;
                end
            end
            start = v.poke && cyc == 4;
            first_addr = start ? ~v.first : v.first;
            last_addr  = start ? ~v.first : v.last;
            hs = bus.out_valid && bus.out_ready;
            step();
            cyc++;
            if (hs) k++;
        end
        start = 1'b0;
        chk("dump_timeout", {63'd0, cyc < 300}, 64'd1);
        chk("beats_seen", k, v.beats);
        chk("beat_cnt", {58'd0, beat_cnt}, v.beats);
        chk("done_pulses", dcnt, 1);
        chk("done_cycle", dcyc, v.exp_done);
        chk("valid_after", {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        int k;
        int n;
        logic hs;
        vec_t v;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        vecs[0] = '{5'd0,  5'd31, 32, 65, 5'd0, 0, 1'b0};
        vecs[1] = '{5'd30, 5'd1,  4,  9,  5'd0, 0, 1'b0};
        vecs[2] = '{5'd7,  5'd7,  1,  3,  5'd0, 0, 1'b0};
        vecs[3] = '{5'd3,  5'd8,  6,  18, 5'd5, 5, 1'b0};
        vecs[4] = '{5'd0,  5'd3,  4,  9,  5'd0, 0, 1'b1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        first_addr = '0; last_addr = '0; bus.out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_rd_addr",   {59'd0, bus.rd_addr}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy}, 64'd0);
        chk("rst_done",      {63'd0, done}, 64'd0);
        chk("rst_beat_cnt",  {58'd0, beat_cnt}, 64'd0);
        step();

        for (int i = 0; i < 5; i++) begin
            run_dump(vecs[i]);
            step();
        end

        // Abort after three accepted beats
        first_addr = 5'd10; last_addr = 5'd20; start = 1'b1; bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        k = 0; n = 0;
        while (k < 3 && n < 50) begin
            hs = bus.out_valid && bus.out_ready;
            step();
            n++;
            if (hs) k++;
        end
        chk("abort_reach", {63'd0, n < 50}, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid",    {63'd0, bus.out_valid}, 64'd0);
        chk("abort_busy",     {63'd0, busy}, 64'd0);
        chk("abort_done",     {63'd0, done}, 64'd0);
        chk("abort_beat_cnt", {58'd0, beat_cnt}, 64'd3);
        step();
        chk("abort_no_done",  {63'd0, done}, 64'd0);
        v = '{5'd0, 5'd0, 1, 3, 5'd0, 0, 1'b0};
        run_dump(v);
        step();

        // Reset while a beat is held
        first_addr = 5'd9; last_addr = 5'd31; start = 1'b1; bus.out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("hold_addr",  {59'd0, bus.out_addr}, 64'd9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("hrst_rd_addr",   {59'd0, bus.rd_addr}, 64'd0);
        chk("hrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("hrst_out_addr",  {59'd0, bus.out_addr}, 64'd0);
        chk("hrst_out_data",  {32'd0, bus.out_data}, 64'd0);
        chk("hrst_busy",      {63'd0, busy}, 64'd0);
        chk("hrst_done",      {63'd0, done}, 64'd0);
        chk("hrst_beat_cnt",  {58'd0, beat_cnt}, 64'd0);
        bus.out_ready = 1'b1;

        // start and abort together in IDLE: start is accepted
        first_addr = 5'd2; last_addr = 5'd2; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", {63'd0, busy}, 64'd1);
        step();
        chk("sa_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("sa_addr",  {59'd0, bus.out_addr}, 64'd2);
        chk("sa_data",  {32'd0, bus.out_data}, 64'h102);
        step();
        chk("sa_done",  {63'd0, done}, 64'd1);
        step();
        chk("sa_idle",  {63'd0, busy}, 64'd0);
        chk("sa_cnt",   {58'd0, beat_cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
